// File: rtl/uart_cmd_rx.sv
// UART receiver that assembles two-byte framed commands {addr, cmd, arg} for the LED manager.
// A high byte (bit7=1) arms the decoder; the next clean low byte completes the 12-bit word.
module uart_cmd_rx #(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD   = 115_200
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx,
    output logic [11:0] cmd_buf,
    output logic        new_cmd,
    output logic        frame_err
);
    localparam int BIT_CLKS  = CLK_HZ / BAUD;
    localparam int HALF_CLKS = BIT_CLKS / 2;
    localparam logic [15:0] BIT_LAST  = 16'(BIT_CLKS - 1);
    localparam logic [15:0] HALF_LAST = 16'(HALF_CLKS - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t      r_state;
    logic        r_rx_meta;
    logic        r_rx_sync;
    logic        r_armed;
    logic [15:0] r_cnt;
    logic [2:0]  r_bit_idx;
    logic [7:0]  r_shift;
    logic        r_pending;
    logic [6:0]  r_stored;
    logic [11:0] r_cmd_buf;
    logic        r_new_cmd;
    logic        r_frame_err;

    assign cmd_buf   = r_cmd_buf;
    assign new_cmd   = r_new_cmd;
    assign frame_err = r_frame_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_rx_meta   <= 1'b1;
            r_rx_sync   <= 1'b1;
            r_armed     <= 1'b1;
            r_cnt       <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_pending   <= 1'b0;
            r_stored    <= '0;
            r_cmd_buf   <= '0;
            r_new_cmd   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_rx_meta   <= rx;
            r_rx_sync   <= r_rx_meta;
            r_new_cmd   <= 1'b0;
            r_frame_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_cnt     <= '0;
                    r_bit_idx <= '0;
                    // After a framing error the line must go high before a new start is accepted
                    if (r_rx_sync) begin
                        r_armed <= 1'b1;
                    end else if (r_armed) begin
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (r_cnt == HALF_LAST) begin
                        r_cnt   <= '0;
                        r_state <= r_rx_sync ? S_IDLE : S_DATA;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                S_DATA: begin
                    if (r_cnt == BIT_LAST) begin
                        r_cnt     <= '0;
                        r_shift   <= {r_rx_sync, r_shift[7:1]};
                        r_bit_idx <= r_bit_idx + 3'd1;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= S_STOP;
                        end
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                S_STOP: begin
                    if (r_cnt == BIT_LAST) begin
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                        if (!r_rx_sync) begin
                            r_frame_err <= 1'b1;
                            r_pending   <= 1'b0;
                            r_armed     <= 1'b0;
                        end else if (r_shift[7]) begin
                            r_stored  <= r_shift[6:0];
                            r_pending <= 1'b1;
                        end else if (r_pending && (r_shift[6:5] == 2'b00)) begin
                            r_cmd_buf <= {r_stored, r_shift[4:0]};
                            r_new_cmd <= 1'b1;
                            r_pending <= 1'b0;
                        end else begin
                            r_pending <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
